// File: rtl/core_pkg.sv
// Shared types and encodings for the load/store path: FSM states, size codes,
// fault codes and the store lane-placement helpers.
package core_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd2;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [4:0] rd;
  } lsu_op_t;

  // Stores only look at funct3[1:0] (4/5 alias b/h); loads need the exact code.
  function automatic logic is_misaligned(input logic store, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic half, word;
    if (store) begin
      half = (f3[1:0] == 2'd1);
      word = f3[1];
    end else begin
      half = (f3 == F3_H) || (f3 == F3_HU);
      word = (f3 == F3_W);
    end
    return (half && off[0]) || (word && (off != 2'd0));
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a raw memory word and extends it.
// Undefined size codes yield zero.
module lsu_load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    b       = shifted[7:0];
    h       = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{b[7]}}, b};
      F3_H:    data_o = {{16{h[15]}}, h};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'd0, b};
      F3_HU:   data_o = {16'd0, h};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: one op per EXU handshake, one MEM request per
// memory op, result handed to WBU with a valid/ready handshake.
module lsu_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_wen,
  output logic [1:0]  out_fault
);

  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  lsu_state_e       state_q, state_d;
  lsu_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             mem_wen_q, mem_wen_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wmask_q, mem_wmask_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_wen_q, out_wen_d;
  logic [1:0]       out_fault_q, out_fault_d;
  logic [31:0]      ld_data;

  lsu_load_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (op_q.off),
    .funct3_i (op_q.funct3),
    .data_o   (ld_data)
  );

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    out_data_d  = out_data_q;
    out_wen_d   = out_wen_q;
    out_fault_d = out_fault_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d        = '{store: in_store, funct3: in_funct3, off: in_addr[1:0], rd: in_rd};
        out_data_d  = 32'd0;
        out_wen_d   = 1'b0;
        out_fault_d = FLT_NONE;
        if (!in_load && !in_store) begin
          out_data_d = in_addr;
          out_wen_d  = (in_rd != 5'd0);
          state_d    = RESP;
        end else if (is_misaligned(in_store, in_funct3, in_addr[1:0])) begin
          out_fault_d = FLT_MISALIGN;
          state_d     = RESP;
        end else begin
          mem_wen_d   = in_store;
          mem_addr_d  = {in_addr[31:2], 2'b00};
          mem_wmask_d = in_store ? store_mask(in_funct3, in_addr[1:0]) : 4'd0;
          mem_wdata_d = in_store ? store_data(in_funct3, in_wdata) : 32'd0;
          state_d     = REQ;
        end
      end
      REQ: if (mem_req_ready) begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        // A response landing on the timeout cycle still wins.
        if (mem_resp_valid) begin
          state_d = RESP;
          if (!op_q.store) begin
            out_data_d = ld_data;
            out_wen_d  = (op_q.rd != 5'd0) &&
                         (op_q.funct3 != 3'd3) && (op_q.funct3[2:1] != 2'b11);
          end
        end else if (TO_EN && (cnt_inc == TO_LIM)) begin
          out_fault_d = FLT_TIMEOUT;
          state_d     = RESP;
        end
      end
      RESP: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
      out_data_q  <= 32'd0;
      out_wen_q   <= 1'b0;
      out_fault_q <= FLT_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      out_data_q  <= out_data_d;
      out_wen_q   <= out_wen_d;
      out_fault_q <= out_fault_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == RESP);
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = {4'd0, mem_wmask_q};
  assign out_rd        = op_q.rd;
  assign out_data      = out_data_q;
  assign out_wen       = out_wen_q;
  assign out_fault     = out_fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: the driver queues expected MEM requests and
// WBU results; negedge monitors pop and compare on each handshake.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_wen;
  logic [1:0]  out_fault;

  lsu_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_wen(out_wen), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; logic wen; logic [1:0] fault; int lat; } out_exp_t;
  typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask; } mem_exp_t;

  out_exp_t oq[$];
  mem_exp_t mq[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Output-side monitor: latency, stability while stalled, then scoreboard pop.
  out_exp_t oe;
  mem_exp_t me;
  logic o_seen = 1'b0, m_seen = 1'b0;
  logic [4:0]  s_rd;
  logic [31:0] s_data, s_maddr, s_mwdata;
  logic        s_wen, s_mwen;
  logic [1:0]  s_fault;
  logic [7:0]  s_mmask;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid) begin
        chk("in_ready_low_in_resp", in_ready, 0);
        if (!o_seen) begin
          o_seen = 1'b1;
          s_rd = out_rd; s_data = out_data; s_wen = out_wen; s_fault = out_fault;
          if (oq.size() > 0) chk("latency", cyc - acc_cyc + 1, oq[0].lat);
        end else begin
          chk("out_rd_stable", out_rd, s_rd);
          chk("out_data_stable", out_data, s_data);
          chk("out_wen_stable", out_wen, s_wen);
          chk("out_fault_stable", out_fault, s_fault);
        end
        if (out_ready) begin
          if (oq.size() == 0) fail_now("unexpected_out_handshake");
          else begin
            oe = oq.pop_front();
            chk("out_rd", out_rd, oe.rd);
            chk("out_data", out_data, oe.data);
            chk("out_wen", out_wen, oe.wen);
            chk("out_fault", out_fault, oe.fault);
          end
          o_seen = 1'b0;
        end
      end
      if (mem_req_valid) begin
        chk("in_ready_low_in_req", in_ready, 0);
        if (!m_seen) begin
          m_seen = 1'b1;
          s_maddr = mem_addr; s_mwdata = mem_wdata; s_mmask = mem_wmask; s_mwen = mem_wen;
          if (mq.size() == 0) fail_now("unexpected_mem_req");
        end else begin
          chk("mem_addr_stable", mem_addr, s_maddr);
          chk("mem_wdata_stable", mem_wdata, s_mwdata);
          chk("mem_wmask_stable", mem_wmask, s_mmask);
          chk("mem_wen_stable", mem_wen, s_mwen);
        end
        if (mem_req_ready) begin
          if (mq.size() > 0) begin
            me = mq.pop_front();
            chk("mem_addr", mem_addr, me.addr);
            chk("mem_wdata", mem_wdata, me.wdata);
            chk("mem_wmask", mem_wmask, me.wmask);
            chk("mem_wen", mem_wen, me.wen);
          end
          m_seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_in_ready();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("in_ready_wait_expired");
  endtask

  task automatic wait_mem_req();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin ok = 1; break; end
    end
    if (!ok) fail_now("mem_req_wait_expired");
  endtask

  task automatic run_op(
    input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
    input int req_wait, input int out_wait, input bit give_resp,
    input bit is_mem, input logic [31:0] m_addr, input logic [31:0] m_wdata,
    input logic [7:0] m_mask,
    input logic [31:0] o_data, input logic o_wen, input logic [1:0] o_fault, input int lat);
    bit ok;
    wait_in_ready();
    #1;
    if (is_mem) mq.push_back('{st, m_addr, m_wdata, m_mask});
    oq.push_back('{rd, o_data, o_wen, o_fault, lat});
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wd; in_rd = rd;
    mem_req_ready = (req_wait == 0);
    out_ready = (out_wait == 0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 0;
    if (is_mem) begin
      wait_mem_req();
      if (req_wait > 0) begin
        repeat (req_wait) @(posedge clk);
        #1 mem_req_ready = 1;
      end
      @(posedge clk);
      #1 mem_req_ready = 0;
      if (give_resp) begin
        mem_resp_valid = 1; mem_rdata = rdata;
        @(posedge clk);
        #1 mem_resp_valid = 0; mem_rdata = 32'd0;
      end
    end
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) fail_now("out_valid_wait_expired");
    if (out_wait > 0) begin
      repeat (out_wait) @(posedge clk);
      #1 out_ready = 1;
    end
    @(posedge clk);
    #1 out_ready = 0;
    mem_req_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; in_load = 0; in_store = 0; in_funct3 = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_out_fault", out_fault, 0);

    //      ld st f3    addr          wdata         rd     rdata        rw ow rsp mem m_addr        m_wdata       mask   o_data        wen flt lat
    run_op(1, 0, 3'd4, 32'h8000_0003, 32'h0,        5'd5,  32'hA1B2_C3D4, 0, 0, 1, 1, 32'h8000_0000, 32'h0,        8'h00, 32'h0000_00A1, 1, 0, 3);
    run_op(1, 0, 3'd1, 32'h8000_0002, 32'h0,        5'd6,  32'h8765_4321, 0, 0, 1, 1, 32'h8000_0000, 32'h0,        8'h00, 32'hFFFF_8765, 1, 0, 3);
    run_op(1, 0, 3'd5, 32'h8000_0002, 32'h0,        5'd7,  32'h8765_4321, 0, 0, 1, 1, 32'h8000_0000, 32'h0,        8'h00, 32'h0000_8765, 1, 0, 3);
    run_op(0, 1, 3'd0, 32'h8000_0001, 32'h1234_56EF, 5'd8, 32'h0,         0, 0, 1, 1, 32'h8000_0000, 32'hEFEF_EFEF, 8'h02, 32'h0,         0, 0, 3);
    run_op(1, 0, 3'd2, 32'h8000_0002, 32'h0,        5'd9,  32'h0,         0, 0, 0, 0, 32'h0,         32'h0,        8'h00, 32'h0,         0, 1, 1);
    run_op(0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0,        5'd10, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,        8'h00, 32'hDEAD_BEEF, 1, 0, 1);
    run_op(0, 0, 3'd0, 32'h1234_5678, 32'h0,        5'd0,  32'h0,         0, 0, 0, 0, 32'h0,         32'h0,        8'h00, 32'h1234_5678, 0, 0, 1);
    // Stalled request and stalled result.
    run_op(0, 1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 5'd12, 32'h0,        5, 4, 1, 1, 32'h8000_0000, 32'hABCD_ABCD, 8'h0C, 32'h0,         0, 0, 8);
    run_op(1, 0, 3'd0, 32'h8000_0001, 32'h0,        5'd11, 32'h0000_80FF, 0, 0, 1, 1, 32'h8000_0000, 32'h0,        8'h00, 32'hFFFF_FF80, 1, 0, 3);
    run_op(1, 0, 3'd2, 32'h8000_0004, 32'h0,        5'd13, 32'h1357_9BDF, 0, 2, 1, 1, 32'h8000_0004, 32'h0,        8'h00, 32'h1357_9BDF, 1, 0, 3);
    // No response: times out after 4 WAIT cycles.
    run_op(1, 0, 3'd2, 32'h8000_0008, 32'h0,        5'd14, 32'h0,         0, 0, 0, 1, 32'h8000_0008, 32'h0,        8'h00, 32'h0,         0, 2, 6);
    run_op(1, 0, 3'd3, 32'h8000_0000, 32'h0,        5'd15, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'h8000_0000, 32'h0,        8'h00, 32'h0,         0, 0, 3);
    run_op(0, 1, 3'd2, 32'h8000_000C, 32'hCAFE_F00D, 5'd16, 32'h0,        0, 0, 1, 1, 32'h8000_000C, 32'hCAFE_F00D, 8'h0F, 32'h0,         0, 0, 3);
    run_op(1, 0, 3'd5, 32'h8000_0001, 32'h0,        5'd17, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,        8'h00, 32'h0,         0, 1, 1);
    run_op(1, 0, 3'd4, 32'h8000_0002, 32'h0,        5'd0,  32'h00FF_0000, 0, 0, 1, 1, 32'h8000_0000, 32'h0,        8'h00, 32'h0000_00FF, 0, 0, 3);

    // Reset while waiting for a response; the late response must be ignored.
    wait_in_ready();
    #1;
    mq.push_back('{1'b0, 32'h8000_0010, 32'h0, 8'h00});
    in_valid = 1; in_load = 1; in_store = 0; in_funct3 = 3'd2;
    in_addr = 32'h8000_0010; in_rd = 5'd18; mem_req_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    wait_mem_req();
    @(posedge clk);
    #1 mem_req_ready = 0; rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("wait_rst_in_ready", in_ready, 1);
    chk("wait_rst_mem_req_valid", mem_req_valid, 0);
    chk("wait_rst_out_valid", out_valid, 0);
    chk("wait_rst_out_data", out_data, 0);
    chk("wait_rst_out_fault", out_fault, 0);
    #1 mem_resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 mem_resp_valid = 0; mem_rdata = 0;
    repeat (3) begin
      @(negedge clk);
      chk("late_resp_out_valid", out_valid, 0);
      chk("late_resp_in_ready", in_ready, 1);
    end

    run_op(1, 0, 3'd2, 32'h8000_0014, 32'h0,        5'd19, 32'h0BAD_F00D, 0, 0, 1, 1, 32'h8000_0014, 32'h0,        8'h00, 32'h0BAD_F00D, 1, 0, 3);

    repeat (3) @(negedge clk);
    chk("out_queue_drained", oq.size(), 0);
    chk("mem_queue_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
